// File: rtl/dff_pipe.sv
// Parametrised valid/ready register pipeline with bubble collapsing,
// synchronous flush, complemented output and registered occupancy count.
module dff_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       resn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qn,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_d;

    // Ready chain from the output back to stage 0; acc[i] means stage i may load.
    always_comb begin
        logic down;
        logic a;
        acc  = '0;
        down = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            a      = ~v_q[i] | (v_q[i] & down);
            acc[i] = a;
            down   = a;
        end
    end

    assign in_ready = acc[0] & ~flush & resn;

    // Next valid vector and per-stage data load enables; flush clears all valids
    // but suppresses data loads so the registers keep their contents.
    always_comb begin
        v_d   = v_q;
        ld    = '0;
        ld[0] = in_valid & in_ready;
        if (acc[0]) begin
            v_d[0] = in_valid & in_ready;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (acc[i]) begin
                v_d[i] = v_q[i-1];
                ld[i]  = v_q[i-1] & ~flush;
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // Popcount of the next valid vector, registered as the occupancy count.
    always_comb begin
        logic [CW-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sum = sum + CW'(v_d[i]);
        end
        count_d = sum;
    end

    // Valid bits and occupancy count.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            v_q   <= '0;
            count <= '0;
        end else begin
            v_q   <= v_d;
            count <= count_d;
        end
    end

    // Stage data registers; load only on transfer.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            if (ld[0]) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (ld[i]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign q         = data_q[DEPTH-1];
    assign qn        = ~q;

endmodule
